// File: rtl/rr_arb_pkg.sv
// Shared types and sizes for the 16-way round-robin arbiter.
package rr_arb_pkg;

  localparam int NUM_REQ = 16;
  localparam int IDX_W   = 4;

  typedef enum logic {IDLE, GRANT} state_t;

  typedef logic [NUM_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0]   idx_t;

endpackage

// File: rtl/rr_arbiter_16_if.sv
// Request/grant bundle. The master side is the arbiter, which drives the grants.
// The slave side is the requester/resource side.
interface rr_arbiter_16_if;
  import rr_arb_pkg::*;

  logic     enable;
  req_vec_t req;
  req_vec_t grant;
  idx_t     grant_idx;
  logic     grant_valid;
  logic     timeout;

  modport master (
    input  enable, req,
    output grant, grant_idx, grant_valid, timeout
  );

  modport slave (
    output enable, req,
    input  grant, grant_idx, grant_valid, timeout
  );
endinterface

// File: rtl/pri_enc_16_4.sv
// Combinational 16-to-4 priority encoder: finds the lowest set bit.
// The valid output is gated by en.
module pri_enc_16_4
  import rr_arb_pkg::*;
(
  input  req_vec_t vec,
  input  logic     en,
  output idx_t     idx,
  output logic     valid
);

  // Scanning downward leaves the lowest set bit as the final assignment.
  always_comb begin
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    valid = en & (|vec);
  end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters, with hold-while-requesting and a MAX_HOLD cap.
// All outputs are registered.
module rr_arbiter_16
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter_16_if.master bus
);

  state_t            state_reg;
  idx_t              ptr_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  req_vec_t          grant_reg;
  idx_t              grant_idx_reg;
  logic              grant_valid_reg;
  logic              timeout_reg;

  req_vec_t rotated;
  idx_t     offset;
  logic     offset_valid;
  idx_t     winner;
  logic     hold_at_max;
  logic     req_granted;

  // Rotate right by ptr so that the requester at ptr lands on bit 0.
  // The 4-bit index sum wraps naturally.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign rotated[gi] = bus.req[IDX_W'(gi) + ptr_reg];
    end
  endgenerate

  pri_enc_16_4 u_enc (
    .vec   (rotated),
    .en    (bus.enable),
    .idx   (offset),
    .valid (offset_valid)
  );

  assign winner      = offset + ptr_reg;
  assign hold_at_max = (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));
  assign req_granted = bus.req[grant_idx_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      ptr_reg         <= '0;
      hold_cnt_reg    <= '0;
      grant_reg       <= '0;
      grant_idx_reg   <= '0;
      grant_valid_reg <= 1'b0;
      timeout_reg     <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (offset_valid) begin
            grant_reg       <= req_vec_t'(1) << winner;
            grant_idx_reg   <= winner;
            grant_valid_reg <= 1'b1;
            hold_cnt_reg    <= '0;
            state_reg       <= GRANT;
          end
        end
        GRANT: begin
          if (!req_granted || hold_at_max) begin
            grant_reg       <= '0;
            grant_idx_reg   <= '0;
            grant_valid_reg <= 1'b0;
            ptr_reg         <= grant_idx_reg + IDX_W'(1);
            // A still-requesting winner can only be released by the hold cap.
            timeout_reg     <= req_granted;
            state_reg       <= IDLE;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_reg;
  assign bus.grant_idx   = grant_idx_reg;
  assign bus.grant_valid = grant_valid_reg;
  assign bus.timeout     = timeout_reg;

endmodule

// File: doc/rr_arbiter_16.md
Name: rr_arbiter_16

Overview:
- Round-robin arbiter that shares one downstream resource among 16 requesters.
- Built around a 16-to-4 priority encoder applied to a rotated request vector.
- Grants are held while the winner keeps requesting, bounded by a maximum hold time.
- Sits in front of any shared datapath in the encoders area; outputs are registered and drive the resource mux select (grant_idx) directly.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one grant may be held; legal range 1..255.
- HOLD_W, 8: width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  when low, no new grant is issued; an existing grant runs to release.
- req  input  16  request vector; bit k = requester k.
- grant  output  16  one-hot grant, registered; all zero when idle.
- grant_idx  output  4  binary index of the granted requester, registered; 0 when idle.
- grant_valid  output  1  high while any grant is active (OR of grant).
- timeout  output  1  one-cycle pulse on the cycle a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (rst high at a clock edge), effective next cycle:
  - grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - ptr=0, hold_cnt=0, state=IDLE.
  - Reset mid-grant drops the grant immediately; it has priority over all other events.
- State IDLE:
  - If enable=1 and req!=0: winner = first set bit of req scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16).
  - Register grant=1<<winner, grant_idx=winner, hold_cnt=0; go to GRANT.
  - Latency from req sampled to grant visible is 1 cycle.
  - Otherwise remain in IDLE with outputs 0.
- State GRANT, evaluated each cycle against the granted index g:
  - Release condition: req[g]=0, or hold_cnt==MAX_HOLD-1.
  - On release: grant, grant_idx and grant_valid clear the next cycle, ptr <= (g+1) mod 16, go to IDLE.
  - timeout=1 for that one cycle only if release was due to hold_cnt and req[g] is still 1.
  - No release: hold_cnt increments and grant is unchanged.
  - enable deasserting in GRANT has no effect on the current grant.
- Each grant is followed by one idle bubble cycle.
  - Example: back-to-back requesters get grants every (hold+1) cycles.
  - Guaranteed fairness: every continuously asserted requester is granted within 15*(MAX_HOLD+1) cycles of asserting.
- Rotation and wrap:
  - ptr wraps from 15 to 0.
  - The winner search wraps; with ptr=14 and req=16'h0003, the winner is 0.
- Request changes:
  - Requests arriving or dropping for non-granted bits during GRANT do not affect the grant.
  - Only req[g] matters.
- Corner values:
  - MAX_HOLD=1: every grant lasts exactly 1 cycle.
  - req=16'hFFFF held constant: grants cycle 0,1,2,...,15,0 in order.
- grant is always one-hot or zero; never two bits set.

Decomposition:
- Shared package rr_arb_pkg holds:
  - NUM_REQ=16, IDX_W=4.
  - typedef state_t {IDLE, GRANT}.
  - typedefs req_vec_t (16 bits) and idx_t (4 bits).
- One sub-module, pri_enc_16_4, combinational:
  - Inputs: 16-bit vector and an enable.
  - Outputs: 4-bit index of the lowest set bit, plus a valid flag.
  - The arbiter rotates req right by ptr, encodes the result, then adds ptr mod 16 to obtain the absolute winner.
- Rotation, the FSM, the hold counter and the output registers live in rr_arbiter_16.

Test Plan:
- Reset behaviour:
  - Stimulus: rst=1 for 2 cycles with req=16'hFFFF and enable=1.
  - Response: grant=0, grant_idx=0, grant_valid=0 throughout.
  - After release, the first grant is idx 0 one cycle later.
- Single requester:
  - Stimulus: req=16'h0010 held 3 cycles, then 0, with MAX_HOLD=8.
  - Response: grant=16'h0010, grant_idx=4 for 3 cycles; 0 one cycle after req drops; timeout never pulses.
- Rotation:
  - Stimulus: req=16'h0011 held constant.
  - Response: grants alternate idx 4 and idx 0 (the first grant is idx 0 from ptr=0); each is held MAX_HOLD cycles, timeout pulses at each revoke, and one idle cycle separates grants.
- Wrap-around:
  - Stimulus: drive a grant of idx 14 and release it (ptr=15), then req=16'h8001.
  - Response: idx 15 is granted next; after its release, idx 0 is granted.
- Enable:
  - Stimulus: enable=0 with req=16'h2000.
  - Response: no grant.
  - Stimulus: deassert enable during an active grant of idx 13.
  - Response: the grant persists until req[13] drops, then no further grants.
- Reset mid-grant and full load:
  - Stimulus: assert rst during a grant of idx 9.
  - Response: grant=0 next cycle and ptr=0.
  - Stimulus: req=16'hFFFF with MAX_HOLD=1.
  - Response: grant_idx sequence 0,1,...,15,0 on every other cycle.
